ddr3_init_seq: RTL and testbench
================================

# ddr3_init_seq

Power-up initialisation sequencer and command multiplexer sitting directly upstream of the DDR3 PHY's DFI command port. After reset it drives the JEDEC DDR3 bring-up sequence onto the DFI command bus: RESET# hold, CKE enable, MR2/MR3/MR1/MR0 mode-register writes, then ZQCL. It then raises `done_o` and hands the bus to the memory controller with a fixed one-cycle register stage. DFI write/read data signals (wstb/wren/mask/data/rden) bypass this block.

## Interface
- `ADDR_BITS`, 14, DDR3 row/column address width.
- `CYCLES_200US`, 20000, cycles RESET# is held low (200 µs at 100 MHz).
- `CYCLES_500US`, 50000, cycles from RESET# high to CKE high.
- `TXPR`, 28, cycles from CKE high to first MRS.
- `TMRD`, 4, cycles between consecutive MRS commands.
- `TMOD`, 12, cycles from MR0 to ZQCL.
- `TZQINIT`, 512, cycles from ZQCL to `done_o`.
- `MR0_VAL`, `MR1_VAL`, `MR2_VAL`, `MR3_VAL`, board-specific, `ADDR_BITS`-wide mode-register payloads.

Ports:
- `clock` in 1: single clock, same domain as PHY `clock`.
- `reset` in 1: synchronous, active-high.
- `ctl_cs_ni`, `ctl_ras_ni`, `ctl_cas_ni`, `ctl_we_ni`, `ctl_odt_i` in 1 each: controller command bits.
- `ctl_bank_i` in 3: controller bank.
- `ctl_addr_i` in `ADDR_BITS`: controller address.
- `dfi_cke_o`, `dfi_rst_no`, `dfi_cs_no`, `dfi_ras_no`, `dfi_cas_no`, `dfi_we_no`, `dfi_odt_o` out 1 each: to the PHY.
- `dfi_bank_o` out 3; `dfi_addr_o` out `ADDR_BITS`: to the PHY.
- `done_o` out 1: initialisation complete; the controller may issue commands.

## Operation
- FSM states: `ST_RST` → `ST_CKE` → `ST_XPR` → `ST_MR2` → `ST_MR3` → `ST_MR1` → `ST_MR0` → `ST_ZQ` → `ST_DONE`.
- A single down-counter (width ⌈log2(max param)⌉+1) is loaded on each state entry. The state advances when the counter reaches zero.
- `ST_RST`: rst_n=0, cke=0, cs_n=1 (deselect).
- `ST_CKE`: rst_n=1, cke=0, deselect.
- `ST_XPR`: cke=1, NOP (cs/ras/cas/we = 0/1/1/1).
- `ST_MRx`:
  - First cycle issues MRS (0/0/0/0), bank = x, addr = `MRx_VAL`.
  - Remaining cycles are NOP.
- `ST_ZQ`: first cycle issues ZQCL (0/1/1/0), bank=0, addr = only A10=1. Remaining cycles are NOP.
- `ST_DONE`: all dfi_* outputs are registered copies of ctl_* inputs; cke=1, rst_n=1.
- ODT is 0 in every state except `ST_DONE`. Controller inputs are ignored while `done_o`=0.
- `ST_DONE` is terminal until `reset`.

## Timing
- All outputs are registered.
- Reset values:
  - `dfi_rst_no`=0, `dfi_cke_o`=0, `dfi_cs_no`=1, `dfi_ras_no`/`dfi_cas_no`/`dfi_we_no`=1.
  - `dfi_odt_o`=0, `dfi_bank_o`=0, `dfi_addr_o`=0, `done_o`=0.
- Edge spacing, counted from the first cycle with `reset`=0:
  - `dfi_rst_no` rises after exactly `CYCLES_200US` cycles.
  - `dfi_cke_o` rises `CYCLES_500US` cycles later.
  - MR2 issues `TXPR` cycles after the CKE rise.
  - MR3, MR1 and MR0 each follow the previous MRS by `TMRD` cycles.
  - ZQCL follows MR0 by `TMOD` cycles.
  - `done_o` rises `TZQINIT` cycles after ZQCL.
- Each MRS and ZQCL command is asserted for exactly one cycle.
- Pass-through latency in `ST_DONE`: 1 cycle, ctl_* at cycle n → dfi_* at n+1. The first forwarded command is the ctl_* value sampled in the cycle `done_o` rises.
- `reset` asserted mid-sequence or in `ST_DONE`: on the next edge all outputs take their reset values and the FSM returns to `ST_RST`. The full sequence restarts with full delays.
- Parameters ≥1 are legal. A value of 1 gives back-to-back states with no extra NOP cycle.

## Structure
- Shared package `ddr3_pkg` holds:
  - command encodings `CMD_NOP`, `CMD_MRS`, `CMD_ZQCL`, `CMD_DESEL` as {cs,ras,cas,we};
  - the FSM state enum;
  - the A10 bit index.
- No sub-module: the counter and FSM are inline. The output register stage is shared between init and pass-through modes.

## Test plan
All scenarios use `CYCLES_200US`=8, `CYCLES_500US`=12, `TXPR`=5, `TMRD`=4, `TMOD`=12, `TZQINIT`=16, and `MR0_VAL`..`MR3_VAL` = 'h0120/'h0044/'h0008/'h0000.

- **Reset release → edges:** `dfi_rst_no` rises at cycle 8, `dfi_cke_o` at 20, MR2 at 25, MR3 at 29, MR1 at 33, MR0 at 37, ZQCL at 49, `done_o` at 65.
- **MRS payloads:** check bank/addr on each MRS cycle = 2/'h0008, 3/'h0000, 1/'h0044, 0/'h0120. ZQCL has addr='h0400. All other init cycles after CKE rise are NOP with ODT=0.
- **Controller ignored before done:** toggle ctl_* randomly during init → dfi_* unaffected.
- **Pass-through after done:** ctl ACT (0/0/1/1, bank 5, addr 'h1234) at cycle n → identical on dfi_* at n+1.
- **Mid-sequence reset:** assert `reset` for 1 cycle at cycle 30 → reset values next cycle, then the full 65-cycle sequence repeats.
- **Minimum parameters:** all delays = 1 → the sequence completes in 8 cycles with no illegal overlap of MRS and ZQCL.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 power-up sequencer: DFI command encodings,
// sequencer states and small elaboration-time helpers.
package ddr3_pkg;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_ZQCL  = 4'b0110;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        ST_RST,
        ST_CKE,
        ST_XPR,
        ST_MR2,
        ST_MR3,
        ST_MR1,
        ST_MR0,
        ST_ZQ,
        ST_DONE
    } init_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_init_seq.sv
// DDR3 bring-up sequencer in front of the DFI command port; after ZQCL it
// forwards controller commands through the same one-cycle output register.
module ddr3_init_seq
    import ddr3_pkg::*;
#(
    parameter int                   ADDR_BITS    = 14,
    parameter int                   CYCLES_200US = 20000,
    parameter int                   CYCLES_500US = 50000,
    parameter int                   TXPR         = 28,
    parameter int                   TMRD         = 4,
    parameter int                   TMOD         = 12,
    parameter int                   TZQINIT      = 512,
    parameter logic [ADDR_BITS-1:0] MR0_VAL      = ADDR_BITS'('h0120),
    parameter logic [ADDR_BITS-1:0] MR1_VAL      = ADDR_BITS'('h0044),
    parameter logic [ADDR_BITS-1:0] MR2_VAL      = ADDR_BITS'('h0008),
    parameter logic [ADDR_BITS-1:0] MR3_VAL      = ADDR_BITS'('h0000)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctl_cs_ni,
    input  logic                 ctl_ras_ni,
    input  logic                 ctl_cas_ni,
    input  logic                 ctl_we_ni,
    input  logic                 ctl_odt_i,
    input  logic [2:0]           ctl_bank_i,
    input  logic [ADDR_BITS-1:0] ctl_addr_i,
    output logic                 dfi_cke_o,
    output logic                 dfi_rst_no,
    output logic                 dfi_cs_no,
    output logic                 dfi_ras_no,
    output logic                 dfi_cas_no,
    output logic                 dfi_we_no,
    output logic                 dfi_odt_o,
    output logic [2:0]           dfi_bank_o,
    output logic [ADDR_BITS-1:0] dfi_addr_o,
    output logic                 done_o
);

    localparam int MAX_P = max2(max2(max2(CYCLES_200US, CYCLES_500US), max2(TXPR, TMRD)),
                                max2(TMOD, TZQINIT));
    localparam int CW    = $clog2(MAX_P) + 1;

    // Counter is loaded with (delay - 1) so a state lasts exactly `delay` cycles.
    localparam logic [CW-1:0] LD_200US = CW'(CYCLES_200US - 1);
    localparam logic [CW-1:0] LD_500US = CW'(CYCLES_500US - 1);
    localparam logic [CW-1:0] LD_XPR   = CW'(TXPR - 1);
    localparam logic [CW-1:0] LD_MRD   = CW'(TMRD - 1);
    localparam logic [CW-1:0] LD_MOD   = CW'(TMOD - 1);
    localparam logic [CW-1:0] LD_ZQ    = CW'(TZQINIT - 1);

    localparam logic [ADDR_BITS-1:0] ZQ_ADDR = ADDR_BITS'(1) << A10_BIT;

    init_state_t   state;
    logic [CW-1:0] cnt;

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; blocking '=' would create ordering-dependent logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RST;
            cnt        <= LD_200US;
            dfi_rst_no <= 1'b0;
            dfi_cke_o  <= 1'b0;
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_DESEL;
            dfi_odt_o  <= 1'b0;
            dfi_bank_o <= '0;
            dfi_addr_o <= '0;
            done_o     <= 1'b0;
        end else if (state == ST_DONE) begin
            {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <=
                {ctl_cs_ni, ctl_ras_ni, ctl_cas_ni, ctl_we_ni};
            dfi_odt_o  <= ctl_odt_i;
            dfi_bank_o <= ctl_bank_i;
            dfi_addr_o <= ctl_addr_i;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            // MRS/ZQCL last one cycle; the rest of a CKE-high state idles on NOP.
            if (state != ST_RST && state != ST_CKE) begin
                {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_NOP;
                dfi_bank_o <= '0;
                dfi_addr_o <= '0;
            end
        end else begin
            case (state)
                ST_RST: begin
                    state      <= ST_CKE;
                    cnt        <= LD_500US;
                    dfi_rst_no <= 1'b1;
                end
                ST_CKE: begin
                    state     <= ST_XPR;
                    cnt       <= LD_XPR;
                    dfi_cke_o <= 1'b1;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_NOP;
                end
                ST_XPR: begin
                    state      <= ST_MR2;
                    cnt        <= LD_MRD;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_MRS;
                    dfi_bank_o <= 3'd2;
                    dfi_addr_o <= MR2_VAL;
                end
                ST_MR2: begin
                    state      <= ST_MR3;
                    cnt        <= LD_MRD;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_MRS;
                    dfi_bank_o <= 3'd3;
                    dfi_addr_o <= MR3_VAL;
                end
                ST_MR3: begin
                    state      <= ST_MR1;
                    cnt        <= LD_MRD;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_MRS;
                    dfi_bank_o <= 3'd1;
                    dfi_addr_o <= MR1_VAL;
                end
                ST_MR1: begin
                    state      <= ST_MR0;
                    cnt        <= LD_MOD;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_MRS;
                    dfi_bank_o <= 3'd0;
                    dfi_addr_o <= MR0_VAL;
                end
                ST_MR0: begin
                    state      <= ST_ZQ;
                    cnt        <= LD_ZQ;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_ZQCL;
                    dfi_bank_o <= 3'd0;
                    dfi_addr_o <= ZQ_ADDR;
                end
                ST_ZQ: begin
                    state      <= ST_DONE;
                    done_o     <= 1'b1;
                    {dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no} <= CMD_NOP;
                    dfi_bank_o <= '0;
                    dfi_addr_o <= '0;
                end
                default: begin
                    state <= ST_RST;
                    cnt   <= LD_200US;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Bench for ddr3_init_seq: cycle-indexed reference of the bring-up sequence
// plus a pass-through scoreboard, on a test-plan instance and a minimum-delay one.
module tb_ddr3_init_seq;

    typedef struct packed {
        logic        rst_n;
        logic        cke;
        logic        cs_n;
        logic        ras_n;
        logic        cas_n;
        logic        we_n;
        logic        odt;
        logic [2:0]  bank;
        logic [13:0] addr;
        logic        done;
    } dfi_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctl_cs_n = 1'b1, ctl_ras_n = 1'b1, ctl_cas_n = 1'b1, ctl_we_n = 1'b1, ctl_odt = 1'b0;
    logic [2:0]  ctl_bank = '0;
    logic [13:0] ctl_addr = '0;

    logic        s_cke, s_rst_n, s_cs_n, s_ras_n, s_cas_n, s_we_n, s_odt, s_done;
    logic [2:0]  s_bank;
    logic [13:0] s_addr;
    logic        m_cke, m_rst_n, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_odt, m_done;
    logic [2:0]  m_bank;
    logic [13:0] m_addr;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ddr3_init_seq #(
        .ADDR_BITS(14), .CYCLES_200US(8), .CYCLES_500US(12), .TXPR(5), .TMRD(4),
        .TMOD(12), .TZQINIT(16), .MR0_VAL(14'h0120), .MR1_VAL(14'h0044),
        .MR2_VAL(14'h0008), .MR3_VAL(14'h0000)
    ) dut (
        .clock(clock), .reset(reset),
        .ctl_cs_ni(ctl_cs_n), .ctl_ras_ni(ctl_ras_n), .ctl_cas_ni(ctl_cas_n),
        .ctl_we_ni(ctl_we_n), .ctl_odt_i(ctl_odt), .ctl_bank_i(ctl_bank), .ctl_addr_i(ctl_addr),
        .dfi_cke_o(s_cke), .dfi_rst_no(s_rst_n), .dfi_cs_no(s_cs_n), .dfi_ras_no(s_ras_n),
        .dfi_cas_no(s_cas_n), .dfi_we_no(s_we_n), .dfi_odt_o(s_odt),
        .dfi_bank_o(s_bank), .dfi_addr_o(s_addr), .done_o(s_done)
    );

    ddr3_init_seq #(
        .ADDR_BITS(14), .CYCLES_200US(1), .CYCLES_500US(1), .TXPR(1), .TMRD(1),
        .TMOD(1), .TZQINIT(1), .MR0_VAL(14'h0120), .MR1_VAL(14'h0044),
        .MR2_VAL(14'h0008), .MR3_VAL(14'h0000)
    ) dut_min (
        .clock(clock), .reset(reset),
        .ctl_cs_ni(ctl_cs_n), .ctl_ras_ni(ctl_ras_n), .ctl_cas_ni(ctl_cas_n),
        .ctl_we_ni(ctl_we_n), .ctl_odt_i(ctl_odt), .ctl_bank_i(ctl_bank), .ctl_addr_i(ctl_addr),
        .dfi_cke_o(m_cke), .dfi_rst_no(m_rst_n), .dfi_cs_no(m_cs_n), .dfi_ras_no(m_ras_n),
        .dfi_cas_no(m_cas_n), .dfi_we_no(m_we_n), .dfi_odt_o(m_odt),
        .dfi_bank_o(m_bank), .dfi_addr_o(m_addr), .done_o(m_done)
    );

    function automatic dfi_t sample(input bit mn);
        dfi_t a;
        if (mn) a = '{m_rst_n, m_cke, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_odt, m_bank, m_addr, m_done};
        else    a = '{s_rst_n, s_cke, s_cs_n, s_ras_n, s_cas_n, s_we_n, s_odt, s_bank, s_addr, s_done};
        return a;
    endfunction

    // Expected outputs in cycle n after reset release; prev is the ctl value driven in cycle n-1.
    function automatic dfi_t model(input bit mn, input int n, input dfi_t prev);
        int   e_rst, e_cke, e_mr2, e_mr3, e_mr1, e_mr0, e_zq, e_done;
        dfi_t e;
        e_rst  = mn ? 1 : 8;
        e_cke  = e_rst + (mn ? 1 : 12);
        e_mr2  = e_cke + (mn ? 1 : 5);
        e_mr3  = e_mr2 + (mn ? 1 : 4);
        e_mr1  = e_mr3 + (mn ? 1 : 4);
        e_mr0  = e_mr1 + (mn ? 1 : 4);
        e_zq   = e_mr0 + (mn ? 1 : 12);
        e_done = e_zq + (mn ? 1 : 16);
        if (n > e_done) begin
            e       = prev;
            e.rst_n = 1'b1;
            e.cke   = 1'b1;
            e.done  = 1'b1;
            return e;
        end
        e = '0;
        {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b1111;
        e.rst_n = (n >= e_rst);
        e.cke   = (n >= e_cke);
        e.done  = (n == e_done);
        if (n >= e_cke) {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0111;
        if (n == e_mr2) begin {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0000; e.bank = 3'd2; e.addr = 14'h0008; end
        if (n == e_mr3) begin {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0000; e.bank = 3'd3; e.addr = 14'h0000; end
        if (n == e_mr1) begin {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0000; e.bank = 3'd1; e.addr = 14'h0044; end
        if (n == e_mr0) begin {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0000; e.bank = 3'd0; e.addr = 14'h0120; end
        if (n == e_zq)  begin {e.cs_n, e.ras_n, e.cas_n, e.we_n} = 4'b0110; e.bank = 3'd0; e.addr = 14'h0400; end
        return e;
    endfunction

    task automatic set_ctl(input dfi_t c);
        ctl_cs_n  = c.cs_n;
        ctl_ras_n = c.ras_n;
        ctl_cas_n = c.cas_n;
        ctl_we_n  = c.we_n;
        ctl_odt   = c.odt;
        ctl_bank  = c.bank;
        ctl_addr  = c.addr;
    endtask

    task automatic drive_random(output dfi_t c);
        c       = '0;
        c.cs_n  = 1'($urandom_range(0, 1));
        c.ras_n = 1'($urandom_range(0, 1));
        c.cas_n = 1'($urandom_range(0, 1));
        c.we_n  = 1'($urandom_range(0, 1));
        c.odt   = 1'($urandom_range(0, 1));
        c.bank  = 3'($urandom_range(0, 7));
        c.addr  = 14'($urandom);
        set_ctl(c);
    endtask

    // Leaves the bench #1 into cycle 0 with reset already low.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        dfi_t exp_r, act;
        exp_r = '0;
        {exp_r.cs_n, exp_r.ras_n, exp_r.cas_n, exp_r.we_n} = 4'b1111;
        for (int d = 0; d < 2; d++) begin
            act = sample(d == 1);
            total++;
            if (act !== exp_r) begin
                bad++;
                $display("FAIL %s dut%0d: got %h want %h", tag, d, act, exp_r);
            end
        end
    endtask

    // Runs ncycles from cycle 0 with random controller traffic, scoreboarding every cycle.
    task automatic run_seq(input bit mn, input int ncycles, input string tag);
        dfi_t q[$];
        dfi_t exp_v, act, c;
        int   r_rst = -1, r_cke = -1, r_done = -1, n_mrs = 0, n_zq = 0;
        q.push_back(model(mn, 0, '0));
        for (int n = 0; n < ncycles; n++) begin
            exp_v = q.pop_front();
            act   = sample(mn);
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, n, act, exp_v);
            end
            if (r_rst < 0 && act.rst_n === 1'b1) r_rst = n;
            if (r_cke < 0 && act.cke === 1'b1) r_cke = n;
            if (r_done < 0 && act.done === 1'b1) r_done = n;
            if (act.done !== 1'b1 && {act.cs_n, act.ras_n, act.cas_n, act.we_n} === 4'b0000) n_mrs++;
            if (act.done !== 1'b1 && {act.cs_n, act.ras_n, act.cas_n, act.we_n} === 4'b0110) n_zq++;
            drive_random(c);
            q.push_back(model(mn, n + 1, c));
            @(posedge clock);
            #1;
        end
        if (ncycles > (mn ? 9 : 66)) begin
            total += 5;
            if (r_rst != (mn ? 1 : 8)) begin bad++; $display("FAIL %s rst_n rise: got %0d want %0d", tag, r_rst, mn ? 1 : 8); end
            if (r_cke != (mn ? 2 : 20)) begin bad++; $display("FAIL %s cke rise: got %0d want %0d", tag, r_cke, mn ? 2 : 20); end
            if (r_done != (mn ? 8 : 65)) begin bad++; $display("FAIL %s done rise: got %0d want %0d", tag, r_done, mn ? 8 : 65); end
            if (n_mrs != 4) begin bad++; $display("FAIL %s mrs count: got %0d want 4", tag, n_mrs); end
            if (n_zq != 1) begin bad++; $display("FAIL %s zqcl count: got %0d want 1", tag, n_zq); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic test_init_sequence();
        run_seq(1'b0, 80, "init");
    endtask

    // Continues in the done state: fixed commands back to back, one-cycle latency each.
    task automatic test_back_to_back();
        dfi_t q[$];
        dfi_t cmds[5];
        dfi_t exp_v, act;
        cmds[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 14'h1234, 1'b0};
        cmds[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 14'h0010, 1'b0};
        cmds[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 14'h0400, 1'b0};
        cmds[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 14'h3fff, 1'b0};
        cmds[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 14'h2aaa, 1'b0};
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) begin
                exp_v = q.pop_front();
                act   = sample(1'b0);
                total++;
                if (act !== exp_v) begin
                    bad++;
                    $display("FAIL passthrough cmd%0d: got %h want %h", i - 1, act, exp_v);
                end
            end
            if (i < 5) begin
                set_ctl(cmds[i]);
                exp_v       = cmds[i];
                exp_v.rst_n = 1'b1;
                exp_v.cke   = 1'b1;
                exp_v.done  = 1'b1;
                q.push_back(exp_v);
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_seq(1'b0, 30, "pre_reset");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_values("mid_reset");
        reset = 1'b0;
        run_seq(1'b0, 72, "restart");
    endtask

    task automatic test_min_params();
        do_reset();
        run_seq(1'b1, 14, "min");
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_back_to_back();
        test_mid_reset();
        test_min_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
